i2c_target_regs: RTL and testbench
==================================

I2C_TARGET_REGS -- requirements
Module: i2c_target_regs

Interface
REQ-001 Parameter TARGET_ADDR, default 7'h50, 7-bit I2C target address this block responds to.
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer depth on scl_in/sda_in (minimum 2).
REQ-003 clk  in  1  system clock; SHALL be at least 10x the SCL frequency.
REQ-004 reset_n  in  1  reset, asynchronous, active-low.
REQ-005 scl_in  in  1  SCL pin level, asynchronous to clk.
REQ-006 sda_in  in  1  SDA pin level, asynchronous to clk.
REQ-007 sda_oe  out  1  1 = pull SDA low (open drain); 0 = release SDA.
REQ-008 reg_sel  in  4  local read index into the register file.
REQ-009 reg_rdata  out  8  regs[reg_sel], combinational.
REQ-010 wr_strobe  out  1  one-clk pulse per register written over I2C.
REQ-011 wr_index  out  4  register index written; valid with wr_strobe.
REQ-012 busy  out  1  1 from an address-matched ACK until STOP.

Function
REQ-013 scl_in/sda_in SHALL pass through SYNC_STAGES flops; all edge detection SHALL use the synchronized values only.
REQ-014 START = synchronized SDA falls while SCL high; STOP = SDA rises while SCL high; both SHALL be honored from any state.
REQ-015 Bits SHALL be sampled on SCL rising edges, MSB first; sda_oe SHALL change only on SCL falling edges, within SYNC_STAGES+1 clks of the pin edge.
REQ-016 States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK_WAIT.
REQ-017 IDLE->ADDR on START; a repeated START in any state SHALL go to ADDR and clear the bit counter.
REQ-018 ADDR: after 8 bits, if bits[7:1]==TARGET_ADDR -> ADDR_ACK (sda_oe=1 for one SCL period); otherwise -> IDLE with sda_oe=0.
REQ-019 After ADDR_ACK: R/W=0 -> PTR; R/W=1 -> RDATA, loading regs[ptr].
REQ-020 PTR: after 8 bits, ptr <= byte[3:0] (bits [7:4] ignored); ACK; -> WDATA.
REQ-021 WDATA: after 8 bits, regs[ptr] <= byte; wr_strobe=1 for one clk with wr_index=ptr; ptr increments; ACK; remain in WDATA.
REQ-022 RDATA: sda_oe = ~bit, MSB driven from the falling edge ending the ACK; after 8 bits release SDA -> RACK_WAIT.
REQ-023 RACK_WAIT: SDA=0 at SCL rise (controller ACK) -> ptr increments, reload, -> RDATA; SDA=1 (NACK) -> IDLE, sda_oe=0.
REQ-024 ptr SHALL be 4 bits and wrap 15->0 on increment.
REQ-025 STOP SHALL release sda_oe within 1 clk and go to IDLE; a partial write byte SHALL be discarded.
REQ-026 Register file: 16 x 8 bits; ptr persists across transactions.

Reset
REQ-027 reset_n low: state=IDLE, sda_oe=0, busy=0, wr_strobe=0, wr_index=0, ptr=0, all regs=8'h00, synchronizers=1.
REQ-028 Reset asserted mid-transfer SHALL release SDA immediately (asynchronously); after release, the block SHALL ignore the bus until the next START.

Verification
REQ-029 Write: START,0xA0,0x03,0x5A,0xC3,STOP -> 4 ACKs; regs[3]=5A, regs[4]=C3; wr_strobe pulses with wr_index 3 then 4.
REQ-030 Read: START,0xA0,0x03,Sr,0xA1, read with ACK then NACK, STOP -> bytes 5A, C3 returned; sda_oe=0 after NACK.
REQ-031 Mismatch: START,0xA2,0x00,STOP -> no ACK (SDA high on 9th clock); regs unchanged; busy stays 0.
REQ-032 Wrap: pointer 0x0F, write 0x11,0x22 -> regs[15]=11, regs[0]=22.
REQ-033 Reset mid-read: reset_n low while driving 0 bit -> sda_oe=0 at once; next valid transaction completes normally.
REQ-034 STOP mid-byte: after 4 WDATA bits -> no register write, no wr_strobe; state IDLE.

Source files
------------

// File: rtl/i2c_target_regs.sv
// I2C target exposing a 16x8 register file through an auto-incrementing 4-bit pointer.
// Bus pins are synchronized into clk; every bus event is derived from the synchronized levels.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | bus ignored until a START
// ADDR      | shifting in the address byte (7-bit address + R/W)
// ADDR_ACK  | address matched, ACK driven for the 9th clock
// PTR       | shifting in the register pointer byte
// PTR_ACK   | ACK driven for the pointer byte
// WDATA     | shifting in a write data byte
// WDATA_ACK | ACK driven for a write data byte (register already written)
// RDATA     | driving regs[ptr] MSB first
// RACK_WAIT | SDA released, waiting for the controller ACK/NACK
module i2c_target_regs #(
    parameter logic [6:0] TARGET_ADDR = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    input  logic [3:0] reg_sel,
    output logic [7:0] reg_rdata,
    output logic       wr_strobe,
    output logic [3:0] wr_index,
    output logic       busy
);

    localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ADDR      = 4'd1,
        ADDR_ACK  = 4'd2,
        PTR       = 4'd3,
        PTR_ACK   = 4'd4,
        WDATA     = 4'd5,
        WDATA_ACK = 4'd6,
        RDATA     = 4'd7,
        RACK_WAIT = 4'd8
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [SYNC_N-1:0] scl_sync;
    logic [SYNC_N-1:0] sda_sync;
    logic              scl_s;
    logic              sda_s;
    logic              scl_q;
    logic              sda_q;
    logic              scl_rise;
    logic              scl_fall;
    logic              start_det;
    logic              stop_det;

    logic [3:0]        bit_cnt;
    logic [7:0]        rx_sr;
    logic [7:0]        tx_sr;
    logic [3:0]        ptr;
    logic [7:0]        regs [16];
    logic [7:0]        ptr_data;
    logic              rack_ack;

    logic              byte_done;
    logic              addr_match;
    logic              rw_bit;

    logic              oe_nxt;
    logic              clr_cnt;
    logic              cnt_en;
    logic              shift_rx;
    logic              load_tx;
    logic              shift_tx;
    logic              set_ptr;
    logic              inc_ptr;
    logic              do_write;
    logic              set_busy;
    logic              set_rack;

    // Synchronizers and the previous synchronized level for edge detection; idle bus is high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_N-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_N-2:0], sda_in};
            scl_q    <= scl_sync[SYNC_N-1];
            sda_q    <= sda_sync[SYNC_N-1];
        end
    end

    assign scl_s     = scl_sync[SYNC_N-1];
    assign sda_s     = sda_sync[SYNC_N-1];
    assign scl_rise  = scl_s & ~scl_q;
    assign scl_fall  = ~scl_s & scl_q;
    assign start_det = scl_s & scl_q & sda_q & ~sda_s;
    assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;

    assign byte_done  = (bit_cnt == 4'd8);
    assign addr_match = (rx_sr[7:1] == TARGET_ADDR);
    assign rw_bit     = rx_sr[0];
    assign ptr_data   = regs[ptr];
    assign reg_rdata  = regs[reg_sel];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Byte boundaries and ACK slots advance on SCL falling edges so SDA only moves while SCL is low.
    always_comb begin
        state_nxt = state;
        if (stop_det) begin
            state_nxt = IDLE;
        end else if (start_det) begin
            state_nxt = ADDR;
        end else begin
            case (state)
                IDLE:      state_nxt = IDLE;
                ADDR:      if (scl_fall && byte_done) state_nxt = addr_match ? ADDR_ACK : IDLE;
                ADDR_ACK:  if (scl_fall) state_nxt = rw_bit ? RDATA : PTR;
                PTR:       if (scl_fall && byte_done) state_nxt = PTR_ACK;
                PTR_ACK:   if (scl_fall) state_nxt = WDATA;
                WDATA:     if (scl_fall && byte_done) state_nxt = WDATA_ACK;
                WDATA_ACK: if (scl_fall) state_nxt = WDATA;
                RDATA:     if (scl_fall && byte_done) state_nxt = RACK_WAIT;
                RACK_WAIT: begin
                    if (scl_rise && sda_s) begin
                        state_nxt = IDLE;
                    end else if (scl_fall && rack_ack) begin
                        state_nxt = RDATA;
                    end
                end
                default:   state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        oe_nxt   = sda_oe;
        clr_cnt  = 1'b0;
        cnt_en   = 1'b0;
        shift_rx = 1'b0;
        load_tx  = 1'b0;
        shift_tx = 1'b0;
        set_ptr  = 1'b0;
        inc_ptr  = 1'b0;
        do_write = 1'b0;
        set_busy = 1'b0;
        set_rack = 1'b0;
        if (stop_det) begin
            oe_nxt  = 1'b0;
            clr_cnt = 1'b1;
        end else if (start_det) begin
            oe_nxt  = 1'b0;
            clr_cnt = 1'b1;
        end else begin
            case (state)
                ADDR, PTR, WDATA: begin
                    if (scl_rise) begin
                        shift_rx = 1'b1;
                        cnt_en   = 1'b1;
                    end
                    if (scl_fall && byte_done) begin
                        clr_cnt  = 1'b1;
                        oe_nxt   = (state != ADDR) || addr_match;
                        set_busy = (state == ADDR) && addr_match;
                        set_ptr  = (state == PTR);
                        do_write = (state == WDATA);
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        load_tx = rw_bit;
                        oe_nxt  = rw_bit & ~ptr_data[7];
                    end
                end
                PTR_ACK, WDATA_ACK: begin
                    if (scl_fall) oe_nxt = 1'b0;
                end
                RDATA: begin
                    if (scl_rise) cnt_en = 1'b1;
                    if (scl_fall) begin
                        if (byte_done) begin
                            oe_nxt  = 1'b0;
                            clr_cnt = 1'b1;
                        end else begin
                            shift_tx = 1'b1;
                            oe_nxt   = ~tx_sr[6];
                        end
                    end
                end
                RACK_WAIT: begin
                    // Pointer advances at the ACK rise so the reload on the following fall sees it.
                    if (scl_rise && !sda_s) begin
                        set_rack = 1'b1;
                        inc_ptr  = 1'b1;
                    end
                    if (scl_fall && rack_ack) begin
                        load_tx = 1'b1;
                        oe_nxt  = ~ptr_data[7];
                    end
                end
                default: oe_nxt = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sda_oe    <= 1'b0;
            bit_cnt   <= 4'd0;
            rx_sr     <= 8'h00;
            tx_sr     <= 8'h00;
            ptr       <= 4'd0;
            rack_ack  <= 1'b0;
            busy      <= 1'b0;
            wr_strobe <= 1'b0;
            wr_index  <= 4'd0;
            for (int i = 0; i < 16; i++) regs[i] <= 8'h00;
        end else begin
            sda_oe    <= oe_nxt;
            wr_strobe <= do_write;
            if (clr_cnt) begin
                bit_cnt <= 4'd0;
            end else if (cnt_en) begin
                bit_cnt <= bit_cnt + 4'd1;
            end
            if (shift_rx) rx_sr <= {rx_sr[6:0], sda_s};
            if (load_tx) begin
                tx_sr <= ptr_data;
            end else if (shift_tx) begin
                tx_sr <= {tx_sr[6:0], 1'b0};
            end
            if (set_ptr) begin
                ptr <= rx_sr[3:0];
            end else if (do_write || inc_ptr) begin
                ptr <= ptr + 4'd1;
            end
            if (do_write) begin
                regs[ptr] <= rx_sr;
                wr_index  <= ptr;
            end
            rack_ack <= (state_nxt == RACK_WAIT) && (rack_ack || set_rack);
            if (stop_det) begin
                busy <= 1'b0;
            end else if (set_busy) begin
                busy <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-banged I2C controller on an open-drain SDA, checked against
// a register-array/pointer model of the target.
module tb_i2c_target_regs;

    localparam int         Q     = 5;
    localparam logic [6:0] TADDR = 7'h50;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ctrl_scl = 1'b1;
    logic       ctrl_sda = 1'b1;
    logic       sda_line;
    logic       sda_oe;
    logic [3:0] reg_sel = 4'd0;
    logic [7:0] reg_rdata;
    logic       wr_strobe;
    logic [3:0] wr_index;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] model_regs [16];
    logic [3:0] model_ptr;
    int         exp_idx_q [$];
    int         got_idx_q [$];
    logic [7:0] wbuf [4];
    logic [7:0] rbuf [4];

    assign sda_line = ctrl_sda & ~sda_oe;

    always #5 clk = ~clk;

    i2c_target_regs #(.TARGET_ADDR(TADDR), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .scl_in    (ctrl_scl),
        .sda_in    (sda_line),
        .sda_oe    (sda_oe),
        .reg_sel   (reg_sel),
        .reg_rdata (reg_rdata),
        .wr_strobe (wr_strobe),
        .wr_index  (wr_index),
        .busy      (busy)
    );

    always @(negedge clk) begin
        if (wr_strobe === 1'b1) got_idx_q.push_back(int'(wr_index));
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wq();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        ctrl_sda = 1'b1; wq();
        ctrl_scl = 1'b1; wq();
        ctrl_sda = 1'b0; wq();
        ctrl_scl = 1'b0; wq();
    endtask

    task automatic i2c_stop();
        ctrl_sda = 1'b0; wq();
        ctrl_scl = 1'b1; wq();
        ctrl_sda = 1'b1; wq();
        wq();
    endtask

    task automatic send_bit(input logic b);
        ctrl_sda = b; wq();
        ctrl_scl = 1'b1; wq();
        wq();
        ctrl_scl = 1'b0; wq();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        ctrl_sda = 1'b1; wq();
        ctrl_scl = 1'b1; wq();
        ack = ~sda_line; wq();
        ctrl_scl = 1'b0; wq();
    endtask

    task automatic read_byte(input logic give_ack, output logic [7:0] d);
        for (int i = 7; i >= 0; i--) begin
            ctrl_sda = 1'b1; wq();
            ctrl_scl = 1'b1; wq();
            d[i] = sda_line; wq();
            ctrl_scl = 1'b0; wq();
        end
        ctrl_sda = ~give_ack; wq();
        ctrl_scl = 1'b1; wq();
        wq();
        ctrl_scl = 1'b0; wq();
        ctrl_sda = 1'b1;
    endtask

    task automatic check_regs();
        for (int i = 0; i < 16; i++) begin
            reg_sel = 4'(i);
            #1;
            check($sformatf("reg[%0d]", i), {24'd0, reg_rdata}, {24'd0, model_regs[i]});
        end
    endtask

    task automatic check_strobes();
        check("strobe_count", got_idx_q.size(), exp_idx_q.size());
        for (int i = 0; i < got_idx_q.size() && i < exp_idx_q.size(); i++)
            check("wr_index", got_idx_q[i], exp_idx_q[i]);
        got_idx_q.delete();
        exp_idx_q.delete();
    endtask

    task automatic check_idle();
        check("busy_off", busy, 1'b0);
        check("oe_idle", sda_oe, 1'b0);
        check_strobes();
        check_regs();
    endtask

    task automatic write_txn(input logic [7:0] ptr_byte, input int n);
        logic ack;
        i2c_start();
        write_byte({TADDR, 1'b0}, ack);
        check("addr_ack", ack, 1'b1);
        check("busy_on", busy, 1'b1);
        write_byte(ptr_byte, ack);
        check("ptr_ack", ack, 1'b1);
        model_ptr = ptr_byte[3:0];
        for (int i = 0; i < n; i++) begin
            write_byte(wbuf[i], ack);
            check("data_ack", ack, 1'b1);
            model_regs[model_ptr] = wbuf[i];
            exp_idx_q.push_back(int'(model_ptr));
            model_ptr = model_ptr + 4'd1;
        end
        i2c_stop();
        check_idle();
    endtask

    task automatic read_body(input int n);
        logic ack;
        write_byte({TADDR, 1'b1}, ack);
        check("raddr_ack", ack, 1'b1);
        for (int i = 0; i < n; i++) begin
            read_byte(i < n - 1, rbuf[i]);
            check("rdata", {24'd0, rbuf[i]}, {24'd0, model_regs[model_ptr]});
            if (i < n - 1) model_ptr = model_ptr + 4'd1;
        end
        check("oe_after_nack", sda_oe, 1'b0);
        i2c_stop();
        check_idle();
    endtask

    task automatic read_txn(input logic [7:0] ptr_byte, input int n);
        logic ack;
        i2c_start();
        write_byte({TADDR, 1'b0}, ack);
        check("addr_ack", ack, 1'b1);
        write_byte(ptr_byte, ack);
        check("ptr_ack", ack, 1'b1);
        model_ptr = ptr_byte[3:0];
        i2c_start();
        read_body(n);
    endtask

    task automatic read_direct(input int n);
        i2c_start();
        read_body(n);
    endtask

    task automatic mismatch_txn(input logic [6:0] a, input logic [7:0] second);
        logic ack;
        i2c_start();
        write_byte({a, 1'b0}, ack);
        check("nomatch_addr_ack", ack, 1'b0);
        check("nomatch_busy", busy, 1'b0);
        write_byte(second, ack);
        check("nomatch_byte_ack", ack, 1'b0);
        i2c_stop();
        check_idle();
    endtask

    task automatic apply_reset();
        for (int i = 0; i < 16; i++) model_regs[i] = 8'h00;
        model_ptr = 4'd0;
        got_idx_q.delete();
        exp_idx_q.delete();
    endtask

    initial begin
        logic ack;
        logic [6:0] a;
        int kind;
        apply_reset();
        repeat (4) @(negedge clk);
        check("rst_sda_oe", sda_oe, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_wr_strobe", wr_strobe, 1'b0);
        check("rst_wr_index", wr_index, 4'd0);
        check_regs();
        reset_n = 1'b1;
        wq();

        // Basic write of two bytes at pointer 3
        wbuf[0] = 8'h5A; wbuf[1] = 8'hC3;
        write_txn(8'h03, 2);
        reg_sel = 4'd3; #1; check("w_reg3", reg_rdata, 8'h5A);
        reg_sel = 4'd4; #1; check("w_reg4", reg_rdata, 8'hC3);

        // Read back with repeated START, ACK then NACK
        read_txn(8'h03, 2);
        check("r_byte0", rbuf[0], 8'h5A);
        check("r_byte1", rbuf[1], 8'hC3);

        // Address mismatch
        mismatch_txn(7'h51, 8'h00);

        // Pointer wrap 15 -> 0
        wbuf[0] = 8'h11; wbuf[1] = 8'h22;
        write_txn(8'h0F, 2);
        reg_sel = 4'd15; #1; check("wrap_reg15", reg_rdata, 8'h11);
        reg_sel = 4'd0;  #1; check("wrap_reg0", reg_rdata, 8'h22);

        // STOP after four bits of a data byte
        i2c_start();
        write_byte({TADDR, 1'b0}, ack);
        check("part_addr_ack", ack, 1'b1);
        write_byte(8'h06, ack);
        check("part_ptr_ack", ack, 1'b1);
        model_ptr = 4'd6;
        for (int i = 0; i < 4; i++) send_bit(1'($urandom));
        i2c_stop();
        check_idle();
        read_direct(1);

        // Reset while the target drives a 0 data bit
        wbuf[0] = 8'h3C;
        write_txn(8'h07, 1);
        i2c_start();
        write_byte({TADDR, 1'b0}, ack);
        write_byte(8'h07, ack);
        i2c_start();
        write_byte({TADDR, 1'b1}, ack);
        check("rr_addr_ack", ack, 1'b1);
        check("rr_drive_low", sda_oe, 1'b1);
        reset_n = 1'b0;
        #1;
        check("rr_oe_async", sda_oe, 1'b0);
        check("rr_busy_async", busy, 1'b0);
        apply_reset();
        ctrl_sda = 1'b1;
        wq();
        ctrl_scl = 1'b1;
        wq();
        reset_n = 1'b1;
        wq(); wq();
        check_idle();
        wbuf[0] = 8'hA5; wbuf[1] = 8'h0F; wbuf[2] = 8'h96;
        write_txn(8'h0E, 3);
        read_txn(8'h0E, 3);

        // Randomized mix of transactions
        for (int t = 0; t < 14; t++) begin
            kind = $urandom_range(0, 3);
            case (kind)
                0: begin
                    for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
                    write_txn(8'($urandom), $urandom_range(1, 4));
                end
                1: read_txn(8'($urandom), $urandom_range(1, 3));
                2: read_direct($urandom_range(1, 3));
                default: begin
                    a = 7'($urandom);
                    if (a == TADDR) a = TADDR + 7'd1;
                    mismatch_txn(a, 8'($urandom));
                end
            endcase
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
